// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, arbitrates PC redirect (exception over branch), debug counters.
// Outputs combinational from state+inputs (0 latency); exception redirect lands one cycle after acceptance.
module pipe_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              br_req_id,
  input  logic [ADDR_W-1:0] br_addr_id,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_vec,
  input  logic              cnt_clr,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              branch,
  output logic [ADDR_W-1:0] branch_addr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_PEND = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic [15:0]       run_cnt;

  always_comb begin
    state_d     = state;
    vec_d       = vec_q;
    stall       = 6'b000000;
    flush       = 1'b0;
    branch      = 1'b0;
    branch_addr = '0;
    case (state)
      RUN: begin
        if (exc_req) begin
          vec_d = exc_vec;
          // A stalled MEM stage must finish its access before the pipe is flushed.
          if (stallreq_mem) begin
            stall   = 6'b011111;
            state_d = EXC_PEND;
          end else begin
            stall   = 6'b111111;
            state_d = FLUSH;
          end
        end else begin
          if (stallreq_mem)     stall = 6'b011111;
          else if (stallreq_ex) stall = 6'b001111;
          else if (stallreq_id) stall = 6'b000111;
          if (br_req_id && (stall == 6'b000000)) begin
            branch      = 1'b1;
            branch_addr = br_addr_id;
          end
        end
      end
      EXC_PEND: begin
        if (stallreq_mem) begin
          stall = 6'b011111;
        end else begin
          stall   = 6'b111111;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush       = 1'b1;
        branch      = 1'b1;
        branch_addr = vec_q;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      vec_q <= '0;
    end else begin
      state <= state_d;
      vec_q <= vec_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall[0] && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Watchdog counts consecutive stalled cycles; flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else if (stall[0]) begin
      if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
      if (run_cnt >= TIMEOUT_M1) stall_timeout <= 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected outputs queued at drive time, compared mid-cycle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        br_req_id, exc_req, cnt_clr;
  logic [31:0] br_addr_id, exc_vec;
  logic [5:0]  stall;
  logic        flush, branch, stall_timeout;
  logic [31:0] branch_addr;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        branch;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl #(.ADDR_W(32), .CNT_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .br_req_id(br_req_id), .br_addr_id(br_addr_id),
    .exc_req(exc_req), .exc_vec(exc_vec), .cnt_clr(cnt_clr),
    .stall(stall), .flush(flush), .branch(branch), .branch_addr(branch_addr),
    .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    br_req_id = 0; br_addr_id = 0; exc_req = 0; exc_vec = 0; cnt_clr = 0;
  endtask

  // Drive one cycle of stimulus ({mem,ex,id}), queue its expected outputs, compare at negedge.
  task automatic step(input string tag, input logic [2:0] sreq, input logic br, input logic [31:0] ba,
                      input logic exc, input logic [31:0] ev, input logic clr,
                      input logic [5:0] es, input logic ef, input logic eb, input logic [31:0] ea);
    exp_t e;
    stallreq_mem = sreq[2]; stallreq_ex = sreq[1]; stallreq_id = sreq[0];
    br_req_id = br; br_addr_id = ba; exc_req = exc; exc_vec = ev; cnt_clr = clr;
    e.stall = es; e.flush = ef; e.branch = eb; e.addr = ea;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_stall"},  64'(stall),       64'(e.stall));
      chk({tag, "_flush"},  64'(flush),       64'(e.flush));
      chk({tag, "_branch"}, 64'(branch),      64'(e.branch));
      chk({tag, "_addr"},   64'(branch_addr), 64'(e.addr));
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk({tag, "_stall"},   64'(stall),         64'd0);
    chk({tag, "_flush"},   64'(flush),         64'd0);
    chk({tag, "_branch"},  64'(branch),        64'd0);
    chk({tag, "_addr"},    64'(branch_addr),   64'd0);
    chk({tag, "_cnt"},     64'(stall_cnt),     64'd0);
    chk({tag, "_timeout"}, 64'(stall_timeout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    do_reset("rst0");

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      step("idle", 3'b000, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
      chk("idle_cnt", 64'(stall_cnt), 64'd0);
    end

    // Stall priority: mem over id, then id alone
    step("mem_id", 3'b101, 0, 0, 0, 0, 0, 6'b011111, 0, 0, 0);
    step("id",     3'b001, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0);
    step("idle2",  3'b000, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    chk("cnt_after_id", 64'(stall_cnt), 64'd2);

    // Branch suppressed while stalled
    step("br_ex", 3'b010, 1, 32'h40, 0, 0, 0, 6'b001111, 0, 0, 0);
    step("br",    3'b000, 1, 32'h40, 0, 0, 0, 6'h00, 0, 1, 32'h40);
    chk("cnt_after_br", 64'(stall_cnt), 64'd3);
    chk("to_clear_a", 64'(stall_timeout), 64'd0);

    // Exception beats same-cycle branch; FLUSH ignores a new exception
    step("exc",       3'b000, 1, 32'h40, 1, 32'h180, 0, 6'h3F, 0, 0, 0);
    step("exc_flush", 3'b000, 1, 32'h44, 1, 32'h200, 0, 6'h00, 1, 1, 32'h180);
    step("exc_run",   3'b000, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    chk("cnt_after_exc", 64'(stall_cnt), 64'd4);

    // Exception waits for MEM, keeps original vector
    step("pend0",  3'b100, 0, 0, 1, 32'h180, 0, 6'b011111, 0, 0, 0);
    step("pend1",  3'b100, 1, 32'h40, 1, 32'h999, 0, 6'b011111, 0, 0, 0);
    step("pend2",  3'b100, 0, 0, 0, 32'h777, 0, 6'b011111, 0, 0, 0);
    step("pend3",  3'b000, 1, 32'h40, 1, 32'h222, 0, 6'h3F, 0, 0, 0);
    step("pend_f", 3'b000, 0, 0, 0, 0, 0, 6'h00, 1, 1, 32'h180);
    step("pend_r", 3'b000, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    chk("cnt_after_pend", 64'(stall_cnt), 64'd8);

    // Watchdog with TIMEOUT=4
    do_reset("rst1");
    for (int i = 0; i < 3; i++)
      step("wd", 3'b100, 0, 0, 0, 0, 0, 6'b011111, 0, 0, 0);
    chk("wd_cnt3", 64'(stall_cnt), 64'd3);
    chk("wd_to3",  64'(stall_timeout), 64'd0);
    step("wd4", 3'b100, 0, 0, 0, 0, 0, 6'b011111, 0, 0, 0);
    chk("wd_cnt4", 64'(stall_cnt), 64'd4);
    chk("wd_to4",  64'(stall_timeout), 64'd1);
    step("clr", 3'b100, 0, 0, 0, 0, 1, 6'b011111, 0, 0, 0);
    chk("clr_cnt", 64'(stall_cnt), 64'd0);
    chk("clr_to",  64'(stall_timeout), 64'd1);
    step("clr_idle", 3'b000, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    chk("to_sticky", 64'(stall_timeout), 64'd1);

    // Reset in EXC_PEND discards the exception
    step("pend_rst", 3'b100, 0, 0, 1, 32'h300, 0, 6'b011111, 0, 0, 0);
    do_reset("rst_mid");
    step("post0", 3'b000, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    step("post1", 3'b000, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    chk("post_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout got=%0d want=0", 1);
    $fatal(1);
  end

endmodule
